// File: rtl/rc_adder.sv
// Registered ripple-carry adder: WIDTH full-adder cells chained LSB to MSB, one-cycle latency.
// Optional two's-complement overflow output enabled by defining RC_ADDER_OVF_EN.

module rc_adder_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

module rc_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
`ifdef RC_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             co
);

    // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_s;
    logic             r_co;

    assign w_carry[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rc_adder_fa u_fa (
            .i_a    (a[i]),
            .i_b    (b[i]),
            .i_cin  (w_carry[i]),
            .o_sum  (w_sum[i]),
            .o_cout (w_carry[i+1])
        );
    end

    // No handshake: the result register loads on every edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s  <= '0;
            r_co <= 1'b0;
        end else begin
            r_s  <= w_sum;
            r_co <= w_carry[WIDTH];
        end
    end

    assign s  = r_s;
    assign co = r_co;

`ifdef RC_ADDER_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign w_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_rc_adder.sv
// Self-checking bench for rc_adder: directed cases, reset behaviour, exhaustive
// and random sweeps checked against an arithmetic reference model.

module tb_rc_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c = 1'b0;
    logic [W-1:0] s;
    logic         co;
`ifdef RC_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rc_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .s     (s),
`ifdef RC_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .co    (co)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned addition, exact in W+1 bits.
    function automatic logic [W:0] model_sum(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                             input logic xc);
        int unsigned t;
        t = int'(xa) + int'(xb) + int'(xc);
        return t[W:0];
    endfunction

    // Reference: signed result out of the W-bit two's-complement range.
    function automatic logic model_ovf(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                       input logic xc);
        longint sa, sb, t;
        sa = xa[W-1] ? longint'(xa) - (longint'(1) << W) : longint'(xa);
        sb = xb[W-1] ? longint'(xb) - (longint'(1) << W) : longint'(xb);
        t  = sa + sb + longint'(xc);
        return (t > (longint'(1) << (W-1)) - 1) || (t < -(longint'(1) << (W-1)));
    endfunction

    function automatic logic [63:0] obs();
        return 64'({co, s});
    endfunction

    // Drive one vector mid-cycle, then check the registered result just after the edge.
    task automatic apply(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc);
        @(negedge clk);
        a = xa;
        b = xb;
        c = xc;
        @(posedge clk);
        #1;
        check(tag, obs(), 64'(model_sum(xa, xb, xc)));
`ifdef RC_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(model_ovf(xa, xb, xc)));
`endif
    endtask

    initial begin
        // Reset held low while inputs toggle: outputs stay zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = W'($urandom_range(0, (1 << W) - 1));
            b = W'($urandom_range(0, (1 << W) - 1));
            c = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("rst_hold", obs(), 64'(0));
`ifdef RC_ADDER_OVF_EN
            check("rst_hold_ovf", 64'(ovf), 64'(0));
`endif
        end

        // First edge after release captures current inputs.
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'd1; b = 4'd1; c = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_rst", obs(), 64'(model_sum(4'd1, 4'd1, 1'b1)));
        check("first_after_rst_s3", 64'(s), 64'(3));

        apply("a0b1c0", 4'd0, 4'd1, 1'b0);
        apply("all_ones_c1", 4'd15, 4'd15, 1'b1);
        check("all_ones_s", 64'(s), 64'(15));
        check("all_ones_co", 64'(co), 64'(1));
        apply("full_ripple", 4'd15, 4'd0, 1'b1);
        check("full_ripple_const", obs(), 64'(5'h10));
        apply("all_zero", 4'd0, 4'd0, 1'b0);
        check("all_zero_const", obs(), 64'(0));

        // Back-to-back vectors on consecutive cycles.
        apply("b2b_0", 4'd0, 4'd0, 1'b1);
        apply("b2b_1", 4'd1, 4'd0, 1'b0);
        apply("b2b_2", 4'd1, 4'd1, 1'b0);
        check("b2b_2_const", obs(), 64'(2));

        apply("ovf_7p1", 4'd7, 4'd1, 1'b0);
        apply("ovf_8p8", 4'd8, 4'd8, 1'b0);
        apply("ovf_3p2", 4'd3, 4'd2, 1'b0);

        // Inputs changing between edges must not reach the outputs early.
        apply("hold_base", 4'd6, 4'd3, 1'b0);
        a = 4'd15; b = 4'd15; c = 1'b1;
        #2;
        check("between_edges", obs(), 64'(9));
        @(posedge clk);
        #1;
        check("between_edges_next", obs(), 64'(31));

        // Asynchronous reset mid-cycle clears at once and discards the in-flight result.
        apply("pre_async", 4'd15, 4'd15, 1'b1);
        #2;
        a = 4'd9; b = 4'd9; c = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_clear", obs(), 64'(0));
`ifdef RC_ADDER_OVF_EN
        check("async_clear_ovf", 64'(ovf), 64'(0));
`endif
        @(posedge clk);
        #1;
        check("async_hold", obs(), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'd2; b = 4'd3; c = 1'b0;
        @(posedge clk);
        #1;
        check("no_stale", obs(), 64'(5));

        // Exhaustive sweep.
        for (int i = 0; i < 512; i++) begin
            apply("sweep", W'(i >> 5), W'(i >> 1), 1'(i));
        end

        // Random vectors.
        for (int i = 0; i < 200; i++) begin
            apply("rand", W'($urandom_range(0, (1 << W) - 1)),
                  W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
